// File: rtl/iccm_load_pkg.sv
// ---------------------------------------------------------------------------
// iccm_load_pkg
// Shared types and constants for the ICCM boot loader / port arbiter.
//   load_state_e     : loader FSM states (IDLE, LOAD, RELEASE, RUN)
//   DefaultEndMarker : terminating word of a program stream (never written)
//   ByteOrder        : 0 = MSB-first packing (first UART byte -> bits [31:24])
//   pack_byte        : appends one received byte below the bytes already held
// ---------------------------------------------------------------------------
package iccm_load_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLoad    = 2'd1,
    StRelease = 2'd2,
    StRun     = 2'd3
  } load_state_e;

  localparam logic [31:0] DefaultEndMarker = 32'h0000_0FFF;

  // 0: MSB-first. The first byte of a word ends up in [31:24], the last in [7:0].
  localparam int unsigned ByteOrder = 32'd0;

  // Completes a word from the three bytes already shifted in plus the newest one.
  function automatic logic [31:0] pack_byte(input logic [23:0] prev, input logic [7:0] b);
    return {prev, b};
  endfunction

endpackage

// File: rtl/uart_word_packer.sv
// ---------------------------------------------------------------------------
// uart_word_packer
// Packs a UART byte stream MSB-first into 32-bit words.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   clear_i        : drop any partial word; a byte on the same cycle starts a new word
//   byte_valid_i   : byte_i is valid this cycle
//   byte_i         : received byte
//   word_o         : completed word (valid only with word_valid_o)
//   word_valid_o   : combinational strobe, high on the cycle the 4th byte arrives
// ---------------------------------------------------------------------------
module uart_word_packer
  import iccm_load_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  cnt_eff_s;

  // Byte count as seen this cycle: a clear makes the incoming byte the first one.
  assign cnt_eff_s    = clear_i ? 2'd0 : cnt_q;
  assign word_o       = pack_byte(shift_q, byte_i);
  assign word_valid_o = byte_valid_i && (cnt_eff_s == 2'd3);

  // Next-state for the shift register and byte counter.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_eff_s;
    if (byte_valid_i) begin
      // Stale bytes left after a clear are pushed out before the next word completes.
      shift_d = {shift_q[15:0], byte_i};
      cnt_d   = cnt_eff_s + 2'd1;
    end else begin
      shift_d = shift_q;
    end
  end

  // Packer state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= 24'h00_0000;
      cnt_q   <= 2'd0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/iccm_load_arbiter.sv
// ---------------------------------------------------------------------------
// iccm_load_arbiter
// Owns the single ICCM SRAM port. After reset it loads a program from the
// UART byte stream (sel_i=1) or the SPI word stream (sel_i=0) into
// consecutive word addresses, then releases the core and hands the port to
// the core fetch path.
// Ports:
//   clk_i, rst_ni             : clock, asynchronous active-low reset
//   sel_i                     : source select, 1 = UART, 0 = SPI
//   uart_dv_i, uart_byte_i    : UART byte strobe and data
//   spi_valid_i, spi_word_i   : SPI word strobe and data
//   fetch_req_i, fetch_addr_i : core fetch request (used in RUN only)
//   fetch_gnt_o               : fetch grant, combinational in RUN
//   mem_*_o                   : SRAM port (loader writes or core reads)
//   core_rst_no               : core reset, low until RUN
//   load_done_o, load_err_o   : sticky end-marker / overflow flags
//   word_count_o              : number of words written
// ---------------------------------------------------------------------------
module iccm_load_arbiter
  import iccm_load_pkg::*;
#(
  parameter int unsigned AddrWidth = 12,
  parameter logic [31:0] EndMarker = iccm_load_pkg::DefaultEndMarker
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 sel_i,
  input  logic                 uart_dv_i,
  input  logic [7:0]           uart_byte_i,
  input  logic                 spi_valid_i,
  input  logic [31:0]          spi_word_i,
  input  logic                 fetch_req_i,
  input  logic [AddrWidth-1:0] fetch_addr_i,
  output logic                 fetch_gnt_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  output logic [3:0]           mem_wmask_o,
  output logic                 core_rst_no,
  output logic                 load_done_o,
  output logic                 load_err_o,
  output logic [AddrWidth:0]   word_count_o
);

  load_state_e          state_q, state_d;
  logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrWidth:0]   count_q, count_d;
  logic                 wr_req_q, wr_req_d;
  logic [AddrWidth-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]          wr_data_q, wr_data_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 core_rst_n_q;
  logic                 sel_q;

  logic        accept_s, run_s, beat_s, word_done_s;
  logic [31:0] word_s, pk_word_s;
  logic        pk_valid_s;

  assign accept_s = (state_q == StIdle) || (state_q == StLoad);
  assign run_s    = (state_q == StRun);
  assign beat_s   = accept_s && (sel_i ? uart_dv_i : spi_valid_i);

  // Any select change restarts UART packing; the write pointer is unaffected.
  uart_word_packer u_packer (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (sel_i != sel_q),
    .byte_valid_i (accept_s && sel_i && uart_dv_i),
    .byte_i       (uart_byte_i),
    .word_o       (pk_word_s),
    .word_valid_o (pk_valid_s)
  );

  assign word_done_s = accept_s && (sel_i ? pk_valid_s : spi_valid_i);
  assign word_s      = sel_i ? pk_word_s : spi_word_i;

  // FSM next state plus loader write/pointer/flag updates.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    wr_req_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    err_d     = err_q;

    case (state_q)
      StIdle: begin
        if (beat_s) state_d = StLoad;
        else        state_d = StIdle;
      end
      StLoad:    state_d = StLoad;
      StRelease: state_d = StRun;
      StRun:     state_d = StRun;
      default:   state_d = StIdle;
    endcase

    if (word_done_s) begin
      if (word_s == EndMarker) begin
        done_d  = 1'b1;
        state_d = StRelease;
      end else begin
        wr_req_d  = 1'b1;
        wr_addr_d = wr_ptr_q;
        wr_data_d = word_s;
        count_d   = count_q + (AddrWidth+1)'(1);
        // The last address is written but the pointer never wraps.
        if (wr_ptr_q == {AddrWidth{1'b1}}) begin
          err_d   = 1'b1;
          state_d = StRelease;
        end else begin
          wr_ptr_d = wr_ptr_q + AddrWidth'(1);
        end
      end
    end else begin
      wr_req_d = 1'b0;
    end
  end

  // State, pointer, write pipeline and status registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      wr_req_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 32'h0000_0000;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      core_rst_n_q <= 1'b0;
      sel_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      wr_req_q     <= wr_req_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      done_q       <= done_d;
      err_q        <= err_d;
      core_rst_n_q <= (state_d == StRun);
      sel_q        <= sel_i;
    end
  end

  // Port mux: registered loader writes until RUN, then a combinational fetch path.
  assign mem_req_o    = run_s ? fetch_req_i  : wr_req_q;
  assign mem_we_o     = run_s ? 1'b0         : wr_req_q;
  assign mem_addr_o   = run_s ? fetch_addr_i : wr_addr_q;
  assign mem_wdata_o  = run_s ? 32'h0000_0000 : wr_data_q;
  assign mem_wmask_o  = (!run_s && wr_req_q) ? 4'hF : 4'h0;
  assign fetch_gnt_o  = run_s && fetch_req_i;

  assign core_rst_no  = core_rst_n_q;
  assign load_done_o  = done_q;
  assign load_err_o   = err_q;
  assign word_count_o = count_q;

endmodule

// File: tb/tb_iccm_load_arbiter.sv
// ---------------------------------------------------------------------------
// tb_iccm_load_arbiter
// Directed and randomized stimulus for iccm_load_arbiter (AddrWidth = 4),
// checked against a queue-based reference model of the boot-load rules.
// ---------------------------------------------------------------------------
module tb_iccm_load_arbiter;

  localparam int AW = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          sel_i = 1'b0;
  logic          uart_dv_i = 1'b0;
  logic [7:0]    uart_byte_i = 8'h00;
  logic          spi_valid_i = 1'b0;
  logic [31:0]   spi_word_i = 32'h0;
  logic          fetch_req_i = 1'b0;
  logic [AW-1:0] fetch_addr_i = '0;
  logic          fetch_gnt_o, mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [3:0]    mem_wmask_o;
  logic          core_rst_no, load_done_o, load_err_o;
  logic [AW:0]   word_count_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0] m_bytes[$];
  int         m_ptr, m_count, m_age;
  bit         m_sel, m_done, m_err, m_fin;

  iccm_load_arbiter #(.AddrWidth(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .sel_i(sel_i),
    .uart_dv_i(uart_dv_i), .uart_byte_i(uart_byte_i),
    .spi_valid_i(spi_valid_i), .spi_word_i(spi_word_i),
    .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i),
    .fetch_gnt_o(fetch_gnt_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .core_rst_no(core_rst_no), .load_done_o(load_done_o), .load_err_o(load_err_o),
    .word_count_o(word_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bytes.delete();
    m_ptr = 0; m_count = 0; m_age = 0;
    m_sel = 1'b0; m_done = 1'b0; m_err = 1'b0; m_fin = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   64'(mem_req_o),    64'd0);
    chk({tag, "_we"},    64'(mem_we_o),     64'd0);
    chk({tag, "_addr"},  64'(mem_addr_o),   64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata_o),  64'd0);
    chk({tag, "_wmask"}, 64'(mem_wmask_o),  64'd0);
    chk({tag, "_gnt"},   64'(fetch_gnt_o),  64'd0);
    chk({tag, "_crst"},  64'(core_rst_no),  64'd0);
    chk({tag, "_done"},  64'(load_done_o),  64'd0);
    chk({tag, "_err"},   64'(load_err_o),   64'd0);
    chk({tag, "_count"}, 64'(word_count_o), 64'd0);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear at once.
  task automatic do_reset(input string tag);
    #2;
    rst_ni = 1'b0;
    sel_i = 1'b0; uart_dv_i = 1'b0; spi_valid_i = 1'b0; fetch_req_i = 1'b0;
    #1;
    chk_all_zero(tag);
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  // One clock of stimulus; model the cycle and compare after the edge.
  task automatic step(input logic sel, input logic udv, input logic [7:0] ub,
                      input logic svld, input logic [31:0] sw,
                      input logic freq, input logic [AW-1:0] faddr);
    logic [31:0]   w;
    bit            have, e_req, run;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_data;
    sel_i = sel; uart_dv_i = udv; uart_byte_i = ub;
    spi_valid_i = svld; spi_word_i = sw;
    fetch_req_i = freq; fetch_addr_i = faddr;
    @(posedge clk_i);
    #1;
    have = 1'b0; e_req = 1'b0; e_addr = '0; e_data = 32'h0; w = 32'h0;
    if (m_fin) m_age++;
    if (!m_fin) begin
      if (sel != m_sel) m_bytes.delete();
      if (sel && udv) begin
        m_bytes.push_back(ub);
        if (m_bytes.size() == 4) begin
          w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
          m_bytes.delete();
          have = 1'b1;
        end
      end else if (!sel && svld) begin
        w = sw;
        have = 1'b1;
      end
      if (have) begin
        if (w == 32'h0000_0FFF) begin
          m_done = 1'b1; m_fin = 1'b1; m_age = 1;
        end else begin
          e_req = 1'b1; e_addr = AW'(m_ptr); e_data = w;
          m_count++;
          if (m_ptr == (1 << AW) - 1) begin
            m_err = 1'b1; m_fin = 1'b1; m_age = 1;
          end else begin
            m_ptr++;
          end
        end
      end
    end
    m_sel = sel;
    run = m_fin && (m_age >= 2);
    if (run) begin
      chk("run_req",   64'(mem_req_o),   64'(freq));
      chk("run_we",    64'(mem_we_o),    64'd0);
      chk("run_gnt",   64'(fetch_gnt_o), 64'(freq));
      chk("run_wmask", 64'(mem_wmask_o), 64'd0);
      if (freq) chk("run_addr", 64'(mem_addr_o), 64'(faddr));
    end else begin
      chk("ld_req", 64'(mem_req_o),   64'(e_req));
      chk("ld_we",  64'(mem_we_o),    64'(e_req));
      chk("ld_gnt", 64'(fetch_gnt_o), 64'd0);
      if (e_req) begin
        chk("ld_addr",  64'(mem_addr_o),  64'(e_addr));
        chk("ld_wdata", 64'(mem_wdata_o), 64'(e_data));
        chk("ld_wmask", 64'(mem_wmask_o), 64'hF);
      end
    end
    chk("core_rst_n", 64'(core_rst_no),  64'(run));
    chk("load_done",  64'(load_done_o),  64'(m_done));
    chk("load_err",   64'(load_err_o),   64'(m_err));
    chk("word_count", 64'(word_count_o), 64'(m_count));
  endtask

  task automatic idle(input logic sel, input int n);
    for (int i = 0; i < n; i++) step(sel, 1'b0, 8'h00, 1'b0, 32'h0, 1'b0, '0);
  endtask

  task automatic ubyte(input logic [7:0] b);
    step(1'b1, 1'b1, b, 1'b0, 32'h0, 1'b0, '0);
  endtask

  task automatic sword(input logic [31:0] w);
    step(1'b0, 1'b0, 8'h00, 1'b1, w, 1'b0, '0);
  endtask

  initial begin
    logic [7:0] ub_seq [8];
    logic       rs;
    ub_seq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h0F, 8'hFF};

    // Reset values
    do_reset("reset");

    // UART load DEADBEEF then end marker, with gaps between bytes
    for (int i = 0; i < 8; i++) begin
      ubyte(ub_seq[i]);
      if (i % 3 == 1) idle(1'b1, 1);
    end
    idle(1'b1, 3);
    // Same-cycle fetch path in RUN
    fetch_req_i = 1'b1; fetch_addr_i = AW'(5);
    #1;
    chk("fetch_same_cycle_addr", 64'(mem_addr_o), 64'd5);
    chk("fetch_same_cycle_gnt",  64'(fetch_gnt_o), 64'd1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 1'b1, AW'(5));
    step(1'b1, 1'b1, 8'h12, 1'b0, 32'h0, 1'b1, AW'(9));
    idle(1'b1, 1);

    // SPI back-to-back words then marker
    do_reset("reset_spi");
    sword(32'h1111_1111);
    sword(32'h2222_2222);
    sword(32'h3333_3333);
    sword(32'h0000_0FFF);
    idle(1'b0, 3);

    // Unselected UART strobes are ignored
    do_reset("reset_ign");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(i * 37), 1'b0, 32'h0, 1'b0, '0);
    sword(32'h0BAD_F00D);
    sword(32'h0000_0FFF);
    idle(1'b0, 3);

    // Select switch mid-word discards partial bytes
    do_reset("reset_sw");
    ubyte(8'hAA);
    ubyte(8'hBB);
    idle(1'b0, 1);
    sword(32'hCAFE_F00D);
    sword(32'h0000_0FFF);
    idle(1'b0, 3);

    // Overflow: 16 words fill the ICCM, the 17th is ignored
    do_reset("reset_ovf");
    for (int i = 0; i < 16; i++) sword(32'hA000_0000 + 32'(i));
    sword(32'h5555_5555);
    idle(1'b0, 3);

    // Reset mid-load, then the next load starts at address 0
    do_reset("reset_pre_mid");
    sword(32'h0101_0101);
    sword(32'h0202_0202);
    ubyte(8'h77);
    ubyte(8'h66);
    do_reset("reset_mid");
    sword(32'h0303_0303);
    sword(32'h0000_0FFF);
    idle(1'b0, 3);

    // Randomized streams with occasional source flips and stray fetch requests
    for (int r = 0; r < 4; r++) begin
      do_reset("reset_rand");
      rs = 1'($urandom_range(0, 1));
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 15) == 0) rs = ~rs;
        step(rs, 1'($urandom_range(0, 2) != 0), 8'($urandom),
             1'($urandom_range(0, 3) == 0), $urandom,
             1'($urandom_range(0, 1)), AW'($urandom));
      end
      sword(32'h0000_0FFF);
      for (int i = 0; i < 5; i++)
        step(1'b0, 1'b1, 8'($urandom), 1'b1, $urandom, 1'($urandom_range(0, 1)), AW'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
